block_window_loader: RTL and testbench

Maintains the window of up to 12 nearest upcoming blocks for the renderer. On each frame-start pulse it retires blocks the player has passed and fetches new blocks from the time-sorted beat-map BRAM. It computes each slot's signed depth relative to the current song time and publishes the packed 12-slot arrays consumed by the per-pixel block selector. Slot 0 is always the nearest block, so lower indices take render priority downstream.

---
 rtl/block_window_loader.sv | 180 ++++++++++++++++++
 tb/tb_block_window_loader.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/block_window_loader.sv
// Keeps the 12 nearest upcoming beat-map blocks (slot 0 = nearest) and publishes them once per frame.
// The update runs expire -> fetch -> publish, and the output arrays change only in the publish cycle.
module block_window_loader #(
   parameter int NUM_SLOTS   = 12,
   parameter int NUM_RECORDS = 1024,
   parameter int ADDR_W      = 10,
   parameter int LOOKAHEAD   = 4096,
   parameter int EXPIRE      = 256
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic [17:0]            curr_time_in,
   input  logic                   frame_start_in,
   output logic [ADDR_W-1:0]      rec_addr_out,
   input  logic [47:0]            rec_data_in,
   output logic [11:0][11:0]      block_x_out,
   output logic [11:0][11:0]      block_y_out,
   output logic [11:0][13:0]      block_z_out,
   output logic [11:0]            block_color_out,
   output logic [11:0][2:0]       block_direction_out,
   output logic [11:0]            block_visible_out,
   output logic                   busy_out,
   output logic                   done_out
);

   typedef enum logic [2:0] {
      S_IDLE, S_EXPIRE, S_FETCH, S_WAIT1, S_WAIT2, S_CHECK, S_PUBLISH
   } state_t;

   typedef struct packed {
      logic [17:0] t;
      logic [11:0] x;
      logic [11:0] y;
      logic        color;
      logic [2:0]  dir;
      logic        vld;
   } slot_t;

   localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(NUM_RECORDS);
   localparam logic [3:0]      FULL_CNT  = 4'(NUM_SLOTS);

   state_t              state_q, state_d;
   logic [17:0]         t_q, t_d;
   slot_t               slots_q [NUM_SLOTS];
   slot_t               slots_d [NUM_SLOTS];
   logic [3:0]          cnt_q, cnt_d;
   logic [ADDR_W:0]     next_q, next_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                pub;

   logic [18:0]         t19, rt19;
   logic                head_expired, rec_expired, rec_in_range;
   logic                unused_rec_bits;

   assign unused_rec_bits = ^rec_data_in[1:0];

   // All time comparisons are widened to 19 bits so the additions cannot wrap.
   assign t19          = {1'b0, t_q};
   assign rt19         = {1'b0, rec_data_in[47:30]};
   assign head_expired = slots_q[0].vld && (t19 > ({1'b0, slots_q[0].t} + 19'(EXPIRE)));
   assign rec_expired  = t19 > (rt19 + 19'(EXPIRE));
   assign rec_in_range = rt19 <= (t19 + 19'(LOOKAHEAD));

   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      cnt_d   = cnt_q;
      next_d  = next_q;
      addr_d  = addr_q;
      pub     = 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) slots_d[i] = slots_q[i];

      case (state_q)
         S_IDLE: begin
            if (frame_start_in) begin
               t_d     = curr_time_in;
               state_d = S_EXPIRE;
            end
         end
         S_EXPIRE: begin
            if (head_expired) begin
               for (int i = 0; i < NUM_SLOTS - 1; i++) slots_d[i] = slots_q[i+1];
               slots_d[NUM_SLOTS-1] = '0;
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            if (cnt_q == FULL_CNT || next_q == LAST_ADDR) begin
               state_d = S_PUBLISH;
            end else begin
               addr_d  = next_q[ADDR_W-1:0];
               state_d = S_WAIT1;
            end
         end
         S_WAIT1: state_d = S_WAIT2;
         S_WAIT2: state_d = S_CHECK;
         S_CHECK: begin
            if (rec_expired) begin
               next_d  = next_q + (ADDR_W+1)'(1);
               state_d = S_FETCH;
            end else if (rec_in_range) begin
               for (int i = 0; i < NUM_SLOTS; i++) begin
                  if (cnt_q == 4'(i)) begin
                     slots_d[i] = '{t: rec_data_in[47:30], x: rec_data_in[29:18],
                                    y: rec_data_in[17:6], color: rec_data_in[5],
                                    dir: rec_data_in[4:2], vld: 1'b1};
                  end
               end
               cnt_d   = cnt_q + 4'd1;
               next_d  = next_q + (ADDR_W+1)'(1);
               state_d = S_FETCH;
            end else begin
               // Too far ahead: leave next_q pointing at it so the next frame retries it.
               state_d = S_PUBLISH;
            end
         end
         S_PUBLISH: begin
            pub     = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   logic [11:0][13:0] z_calc;

   always_comb begin : z_sat
      logic signed [18:0] diff;
      diff   = '0;
      z_calc = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         diff = $signed({1'b0, slots_q[i].t}) - $signed(t19);
         if (!slots_q[i].vld)        z_calc[i] = '0;
         else if (diff > 19'sd8191)  z_calc[i] = 14'h1FFF;
         else if (diff < -19'sd8192) z_calc[i] = 14'h2000;
         else                        z_calc[i] = diff[13:0];
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q             <= S_IDLE;
         t_q                 <= '0;
         cnt_q               <= '0;
         next_q              <= '0;
         addr_q              <= '0;
         for (int i = 0; i < NUM_SLOTS; i++) slots_q[i] <= '0;
         block_x_out         <= '0;
         block_y_out         <= '0;
         block_z_out         <= '0;
         block_color_out     <= '0;
         block_direction_out <= '0;
         block_visible_out   <= '0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         cnt_q   <= cnt_d;
         next_q  <= next_d;
         addr_q  <= addr_d;
         for (int i = 0; i < NUM_SLOTS; i++) slots_q[i] <= slots_d[i];
         if (pub) begin
            block_z_out <= z_calc;
            for (int i = 0; i < NUM_SLOTS; i++) begin
               block_x_out[i]         <= slots_q[i].vld ? slots_q[i].x   : 12'd0;
               block_y_out[i]         <= slots_q[i].vld ? slots_q[i].y   : 12'd0;
               block_color_out[i]     <= slots_q[i].vld & slots_q[i].color;
               block_direction_out[i] <= slots_q[i].vld ? slots_q[i].dir : 3'd0;
               block_visible_out[i]   <= slots_q[i].vld;
            end
         end
      end
   end

   assign rec_addr_out = addr_q;
   assign busy_out     = (state_q != S_IDLE);
   assign done_out     = (state_q == S_PUBLISH);

endmodule

// File: tb/tb_block_window_loader.sv
// Bench for block_window_loader: a table of frame updates checked against a scoreboard,
// plus hand-written reset sequences.
module tb_block_window_loader;

   localparam int NREC = 20;
   localparam int AW   = 5;

   logic               clk_in = 1'b0;
   logic               rst_in;
   logic [17:0]        curr_time_in;
   logic               frame_start_in;
   logic [AW-1:0]      rec_addr_out;
   logic [47:0]        rec_data_in;
   logic [11:0][11:0]  block_x_out, block_y_out;
   logic [11:0][13:0]  block_z_out;
   logic [11:0]        block_color_out, block_visible_out;
   logic [11:0][2:0]   block_direction_out;
   logic               busy_out, done_out;

   block_window_loader #(
      .NUM_SLOTS(12), .NUM_RECORDS(NREC), .ADDR_W(AW), .LOOKAHEAD(1000), .EXPIRE(256)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in), .curr_time_in(curr_time_in),
      .frame_start_in(frame_start_in), .rec_addr_out(rec_addr_out), .rec_data_in(rec_data_in),
      .block_x_out(block_x_out), .block_y_out(block_y_out), .block_z_out(block_z_out),
      .block_color_out(block_color_out), .block_direction_out(block_direction_out),
      .block_visible_out(block_visible_out), .busy_out(busy_out), .done_out(done_out)
   );

   always #5 clk_in = ~clk_in;

   // Beat-map BRAM with two registered read stages.
   logic [47:0] mem [0:31];
   logic [47:0] d1, d2;
   always @(posedge clk_in) begin
      d1 <= mem[rec_addr_out];
      d2 <= d1;
   end
   assign rec_data_in = d2;

   int tests = 0;
   int fails = 0;

   typedef struct {
      int t;         // frame time
      int step;      // record time spacing in the loaded beat map
      int first;     // beat-map index held in slot 0
      int cnt;       // visible slots
      int addr;      // last address issued
      int busy_cyc;  // cycles busy_out is high
      int extra;     // inject an ignored frame_start_in mid-update
   } row_t;

   row_t rows [6];
   row_t exp_q [$];

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   function automatic int rec_x(input int i); return (i * 7 + 1) & 12'hFFF; endfunction
   function automatic int rec_y(input int i); return (i * 3 + 2) & 12'hFFF; endfunction

   task automatic fill_mem(input int step);
      for (int i = 0; i < 32; i++)
         mem[i] = {18'(step * i), 12'(rec_x(i)), 12'(rec_y(i)), 1'(i & 1), 3'(i % 8), 2'b00};
   endtask

   task automatic run_row(input row_t r);
      int   bcyc  = 0;
      int   ndone = 0;
      bit   seen  = 0;
      row_t e;
      exp_q.push_back(r);
      @(negedge clk_in);
      curr_time_in   = 18'(r.t);
      frame_start_in = 1'b1;
      @(negedge clk_in);
      frame_start_in = 1'b0;
      for (int c = 0; c < 300; c++) begin
         if (busy_out) begin bcyc++; seen = 1; end
         if (done_out) ndone++;
         if (seen && !busy_out) break;
         if (r.extra != 0 && c == 4) begin
            curr_time_in   = 18'(r.t + 500);
            frame_start_in = 1'b1;
         end else begin
            frame_start_in = 1'b0;
         end
         @(negedge clk_in);
      end
      frame_start_in = 1'b0;
      chk($sformatf("update_finished T=%0d", r.t), int'(busy_out), 0);
      e = exp_q.pop_front();
      chk($sformatf("done_pulses T=%0d", e.t), ndone, 1);
      chk($sformatf("busy_cycles T=%0d", e.t), bcyc, e.busy_cyc);
      chk($sformatf("rec_addr T=%0d", e.t), int'(rec_addr_out), e.addr);
      chk($sformatf("visible T=%0d", e.t), int'(block_visible_out), (1 << e.cnt) - 1);
      for (int k = 0; k < 12; k++) begin
         int idx, ez, ex, ey, ec, ed;
         idx = e.first + k;
         ez = 0; ex = 0; ey = 0; ec = 0; ed = 0;
         if (k < e.cnt) begin
            ez = (e.step * idx - e.t) & 14'h3FFF;
            ex = rec_x(idx);
            ey = rec_y(idx);
            ec = idx & 1;
            ed = idx % 8;
         end
         chk($sformatf("z[%0d] T=%0d", k, e.t), int'(block_z_out[k]), ez);
         chk($sformatf("xycd[%0d] T=%0d", k, e.t),
             int'({block_x_out[k], block_y_out[k], block_color_out[k], block_direction_out[k]}),
             (ex << 16) | (ey << 4) | (ec << 3) | ed);
      end
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, " busy"},     int'(busy_out), 0);
      chk({tag, " done"},     int'(done_out), 0);
      chk({tag, " visible"},  int'(block_visible_out), 0);
      chk({tag, " rec_addr"}, int'(rec_addr_out), 0);
      chk({tag, " z0"},       int'(block_z_out[0]), 0);
      chk({tag, " x0y0"},     int'({block_x_out[0], block_y_out[0]}), 0);
   endtask

   initial begin
      rows[0] = '{t: 0,    step: 100, first: 0,  cnt: 11, addr: 11, busy_cyc: 50, extra: 1};
      rows[1] = '{t: 1500, step: 100, first: 13, cnt: 7,  addr: 19, busy_cyc: 50, extra: 0};
      rows[2] = '{t: 1700, step: 100, first: 15, cnt: 5,  addr: 19, busy_cyc: 5,  extra: 0};
      rows[3] = '{t: 0,    step: 50,  first: 0,  cnt: 12, addr: 11, busy_cyc: 51, extra: 0};
      rows[4] = '{t: 0,    step: 50,  first: 0,  cnt: 12, addr: 11, busy_cyc: 3,  extra: 0};
      rows[5] = '{t: 300,  step: 50,  first: 1,  cnt: 12, addr: 12, busy_cyc: 8,  extra: 0};

      fill_mem(100);
      curr_time_in   = '0;
      frame_start_in = 1'b0;
      rst_in         = 1'b1;
      #1;
      check_reset_state("power_on");
      repeat (3) @(negedge clk_in);
      rst_in = 1'b0;

      for (int i = 0; i < 6; i++) begin
         if (i == 3) begin
            // Abort an update with an asynchronous reset between clock edges.
            @(negedge clk_in);
            curr_time_in   = 18'd2000;
            frame_start_in = 1'b1;
            @(negedge clk_in);
            frame_start_in = 1'b0;
            @(negedge clk_in);
            @(negedge clk_in);
            chk("pre_reset busy", int'(busy_out), 1);
            #2 rst_in = 1'b1;
            #1;
            check_reset_state("mid_update_reset");
            @(negedge clk_in);
            rst_in = 1'b0;
            fill_mem(50);
         end
         run_row(rows[i]);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
